time_set_ctrl: RTL
==================

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  BLINK_HALF, 50, CLK100 cycles per blink half-period (0.5 s).
  TIMEOUT, 30, TICK pulses without key activity before an edit is aborted.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK100    in   1  100 Hz system clock.
  RST       in   1  synchronous active-high reset.
  TICK      in   1  1 Hz single-cycle enable from the timebase.
  MODE_EN   in   1  debounced edit-mode switch level.
  KEY_SEL   in   1  debounced field-select key level.
  KEY_INC   in   1  debounced increment key level.
  KEY_DEC   in   1  debounced decrement key level.
  SEC_IN    in   6  current clock seconds.
  MIN_IN    in   6  current clock minutes.
  HOUR_IN   in   5  current clock hours.
  DATE_IN   in   5  current clock date.
  SEC_OUT   out  6  shadow seconds.
  MIN_OUT   out  6  shadow minutes.
  HOUR_OUT  out  5  shadow hours.
  DATE_OUT  out  5  shadow date.
  LOAD      out  1  one-cycle strobe; the clock loads the *_OUT values.
  RUN_EN    out  1  clock counting permitted.
  BLINK     out  4  per-field blank mask: [0] sec, [1] min, [2] hour, [3] date.
REQ-003 The block SHALL use a single clock, CLK100, and a synchronous active-high reset, RST; there SHALL be no other clock or asynchronous reset.

Function
REQ-004 The FSM SHALL have exactly these states: IDLE, SET_SEC, SET_MIN, SET_HOUR, SET_DATE, COMMIT.
REQ-005 Key and MODE_EN edges SHALL be detected against a one-cycle registered copy; an edge seen in cycle N SHALL take effect in the state and registers at N+1.
REQ-006 In IDLE, RUN_EN=1, BLINK=0, and the shadow registers SHALL follow the *_IN values every cycle.
REQ-007 A MODE_EN rising edge in IDLE SHALL capture the *_IN values into the shadows, enter SET_SEC, and set RUN_EN=0.
REQ-008 At capture, out-of-range values SHALL be clamped: sec/min >59 -> 59, hour >23 -> 23, date 0 -> 1, date >31 -> 31.
REQ-009 A KEY_SEL rising edge SHALL advance the field SET_SEC -> SET_MIN -> SET_HOUR -> SET_DATE -> SET_SEC.
REQ-010 A KEY_INC rising edge SHALL increment the current field with wrap: sec/min 59 -> 0, hour 23 -> 0, date 31 -> 1.
REQ-011 A KEY_DEC rising edge SHALL decrement the current field with wrap: sec/min 0 -> 59, hour 0 -> 23, date 1 -> 31.
REQ-012 Simultaneous edges SHALL resolve as follows: INC+DEC in the same cycle SHALL change nothing; a SEL edge SHALL take priority and drop any coincident INC/DEC edge.
REQ-013 A MODE_EN falling edge in any SET_* state SHALL enter COMMIT.
REQ-014 COMMIT SHALL last exactly one cycle with LOAD=1, shadows stable and RUN_EN=0; the next state SHALL be IDLE, where RUN_EN=1.
REQ-015 LOAD SHALL be asserted only in COMMIT.
REQ-016 An inactivity counter SHALL clear on any key edge and count TICK pulses in SET_* states.
REQ-017 When the inactivity count reaches TIMEOUT, the FSM SHALL return to IDLE without LOAD.
REQ-018 After a timeout, a new MODE_EN rising edge SHALL be required to re-enter edit mode.
REQ-019 A blink counter SHALL toggle a phase bit every BLINK_HALF cycles while in SET_* states.
REQ-020 BLINK SHALL be the one-hot bit of the current field when phase=1, and 0 otherwise.
REQ-021 Any key edge SHALL force phase=0 and clear the blink counter, so the edited digit is visible immediately.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On RST=1 at a CLK100 edge, the block SHALL return to IDLE from any state, and no LOAD SHALL be issued.
REQ-024 Reset values SHALL be: LOAD=0, RUN_EN=1, BLINK=0, SEC/MIN/HOUR_OUT=0, DATE_OUT=1, all counters=0.
REQ-025 All edge-history registers SHALL reset to 1, so a MODE_EN held high through reset SHALL NOT enter edit mode.

Structure
REQ-026 Package time_set_pkg SHALL hold the state enumeration, the field one-hot encoding, and the limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DATE_MIN=1, DATE_MAX=31.
REQ-027 One sub-module, edge_rise, SHALL provide the registered rising/falling edge detect and SHALL be instantiated once per key and for MODE_EN.

Verification
REQ-028 Clock at 12:34:56, date 7; MODE_EN rises -> SET_SEC at N+1, RUN_EN=0, shadows 56/34/12/7.
REQ-029 In SET_SEC with sec=59, one KEY_INC -> sec=0; KEY_SEL x3 then KEY_DEC with date=1 -> date=31.
REQ-030 KEY_INC and KEY_DEC edges in the same cycle -> value unchanged; KEY_SEL+KEY_INC together -> field advances and value unchanged.
REQ-031 MODE_EN falls after edits -> LOAD high for exactly 1 cycle carrying the shadow values, then IDLE with RUN_EN=1.
REQ-032 No keys for 30 TICKs in SET_MIN -> IDLE with LOAD never asserted; a 100-cycle window in SET_HOUR -> BLINK[2] toggles at cycles 50 and 100.
REQ-033 RST asserted during SET_DATE -> IDLE next cycle, LOAD=0, DATE_OUT=1, RUN_EN=1.

Source files
------------

// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller.
// Contents:
//   state_t             - edit FSM states
//   FIELD_*             - one-hot per-field encoding used for the BLINK mask
//   SEC_MAX..DATE_MAX   - legal value limits of each time field
//   step6/step5         - wrap-around increment/decrement of a field
//   clamp6/clamp5       - range clamp applied when the live clock is captured
//   field_onehot        - BLINK bit of the field being edited in a state
//   next_field          - field rotation order for the select key
package time_set_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SET_SEC  = 3'd1,
        SET_MIN  = 3'd2,
        SET_HOUR = 3'd3,
        SET_DATE = 3'd4,
        COMMIT   = 3'd5
    } state_t;

    localparam logic [3:0] FIELD_NONE = 4'b0000;
    localparam logic [3:0] FIELD_SEC  = 4'b0001;
    localparam logic [3:0] FIELD_MIN  = 4'b0010;
    localparam logic [3:0] FIELD_HOUR = 4'b0100;
    localparam logic [3:0] FIELD_DATE = 4'b1000;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [4:0] DATE_MIN = 5'd1;
    localparam logic [4:0] DATE_MAX = 5'd31;

    // Wrap-around step; a value already at or beyond a limit wraps to the other end.
    function automatic logic [5:0] step6(input logic [5:0] v, input logic [5:0] lo,
                                         input logic [5:0] hi, input logic up);
        logic [5:0] r;
        if (up) begin
            if (v >= hi) r = lo;
            else         r = v + 6'd1;
        end else begin
            if (v <= lo) r = hi;
            else         r = v - 6'd1;
        end
        return r;
    endfunction

    function automatic logic [4:0] step5(input logic [4:0] v, input logic [4:0] lo,
                                         input logic [4:0] hi, input logic up);
        logic [4:0] r;
        if (up) begin
            if (v >= hi) r = lo;
            else         r = v + 5'd1;
        end else begin
            if (v <= lo) r = hi;
            else         r = v - 5'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] hi);
        logic [5:0] r;
        if (v > hi) r = hi;
        else        r = v;
        return r;
    endfunction

    function automatic logic [4:0] clamp5(input logic [4:0] v, input logic [4:0] lo,
                                          input logic [4:0] hi);
        logic [4:0] r;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        else             r = v;
        return r;
    endfunction

    function automatic logic [3:0] field_onehot(input state_t s);
        logic [3:0] r;
        case (s)
            SET_SEC:  r = FIELD_SEC;
            SET_MIN:  r = FIELD_MIN;
            SET_HOUR: r = FIELD_HOUR;
            SET_DATE: r = FIELD_DATE;
            default:  r = FIELD_NONE;
        endcase
        return r;
    endfunction

    function automatic state_t next_field(input state_t s);
        state_t r;
        case (s)
            SET_SEC:  r = SET_MIN;
            SET_MIN:  r = SET_HOUR;
            SET_HOUR: r = SET_DATE;
            SET_DATE: r = SET_SEC;
            default:  r = IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Signal bundle between the keypad/clock side and the time-set controller.
//   TICK, MODE_EN, KEY_SEL, KEY_INC, KEY_DEC : 1 Hz enable and debounced key levels
//   SEC_IN, MIN_IN, HOUR_IN, DATE_IN         : live clock values
//   SEC_OUT, MIN_OUT, HOUR_OUT, DATE_OUT     : shadow values handed back to the clock
//   LOAD, RUN_EN, BLINK                      : load strobe, run permit, display blank mask
// Modports: master = environment (drives keys and live time), slave = controller.
interface time_set_ctrl_if;
    logic       TICK;
    logic       MODE_EN;
    logic       KEY_SEL;
    logic       KEY_INC;
    logic       KEY_DEC;
    logic [5:0] SEC_IN;
    logic [5:0] MIN_IN;
    logic [4:0] HOUR_IN;
    logic [4:0] DATE_IN;
    logic [5:0] SEC_OUT;
    logic [5:0] MIN_OUT;
    logic [4:0] HOUR_OUT;
    logic [4:0] DATE_OUT;
    logic       LOAD;
    logic       RUN_EN;
    logic [3:0] BLINK;

    modport master (
        output TICK, MODE_EN, KEY_SEL, KEY_INC, KEY_DEC,
        output SEC_IN, MIN_IN, HOUR_IN, DATE_IN,
        input  SEC_OUT, MIN_OUT, HOUR_OUT, DATE_OUT, LOAD, RUN_EN, BLINK
    );

    modport slave (
        input  TICK, MODE_EN, KEY_SEL, KEY_INC, KEY_DEC,
        input  SEC_IN, MIN_IN, HOUR_IN, DATE_IN,
        output SEC_OUT, MIN_OUT, HOUR_OUT, DATE_OUT, LOAD, RUN_EN, BLINK
    );
endinterface

// File: rtl/time_set_ctrl_edge_rise.sv
// Rising/falling edge detector against a one-cycle registered copy of the input.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   d    : level to watch
//   rise : d high now, low last cycle
//   fall : d low now, high last cycle
// The history register resets high so a level already high during reset is
// not reported as a rising edge afterwards.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic prev_r;

    // One-cycle history of the watched level
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= d;
        end
    end

    assign rise = d & ~prev_r;
    assign fall = ~d & prev_r;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: lets the user edit seconds, minutes, hours and date
// of a running clock through MODE/SEL/INC/DEC keys, then loads the edited
// values back in a single strobe.
//   CLK100 : 100 Hz system clock
//   RST    : synchronous active-high reset
//   bus    : time_set_ctrl_if.slave (keys, TICK, live time in; shadows,
//            LOAD, RUN_EN, BLINK out)
// Parameters:
//   BLINK_HALF : clock cycles per blink half-period
//   TIMEOUT    : TICK pulses without key activity before an edit is abandoned
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int BLINK_HALF = 50,
    parameter int TIMEOUT    = 30
) (
    input logic            CLK100,
    input logic            RST,
    time_set_ctrl_if.slave bus
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [IW-1:0] INACT_ZERO = IW'(0);
    localparam logic [IW-1:0] INACT_ONE  = IW'(1);
    localparam logic [IW-1:0] INACT_LAST = IW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BLINK_ZERO = BW'(0);
    localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t        state_r, state_s;
    logic [5:0]    sec_r, sec_s;
    logic [5:0]    min_r, min_s;
    logic [4:0]    hour_r, hour_s;
    logic [4:0]    date_r, date_s;
    logic [IW-1:0] inact_r, inact_s;
    logic [BW-1:0] blink_cnt_r, blink_cnt_s;
    logic          phase_r, phase_s;
    logic          load_r;
    logic          run_en_r;
    logic [3:0]    blink_r;

    logic mode_rise_s, mode_fall_s;
    logic sel_rise_s, sel_fall_s;
    logic inc_rise_s, inc_fall_s;
    logic dec_rise_s, dec_fall_s;
    logic key_edge_s;
    logic inc_only_s;
    logic dec_only_s;
    logic timeout_s;

    edge_rise u_mode_edge (.clk(CLK100), .rst(RST), .d(bus.MODE_EN),
                           .rise(mode_rise_s), .fall(mode_fall_s));
    edge_rise u_sel_edge  (.clk(CLK100), .rst(RST), .d(bus.KEY_SEL),
                           .rise(sel_rise_s), .fall(sel_fall_s));
    edge_rise u_inc_edge  (.clk(CLK100), .rst(RST), .d(bus.KEY_INC),
                           .rise(inc_rise_s), .fall(inc_fall_s));
    edge_rise u_dec_edge  (.clk(CLK100), .rst(RST), .d(bus.KEY_DEC),
                           .rise(dec_rise_s), .fall(dec_fall_s));

    // Any press or release counts as key activity (inactivity and blink restart).
    assign key_edge_s = sel_rise_s | sel_fall_s | inc_rise_s | inc_fall_s |
                        dec_rise_s | dec_fall_s;
    // INC and DEC pressed together cancel out.
    assign inc_only_s = inc_rise_s & ~dec_rise_s;
    assign dec_only_s = dec_rise_s & ~inc_rise_s;
    // Fires on the TICK that would bring the idle count to TIMEOUT.
    assign timeout_s  = bus.TICK & ~key_edge_s & (inact_r == INACT_LAST);

    // Next-state, shadow update and counter logic
    always_comb begin
        state_s     = state_r;
        sec_s       = sec_r;
        min_s       = min_r;
        hour_s      = hour_r;
        date_s      = date_r;
        inact_s     = inact_r;
        blink_cnt_s = blink_cnt_r;
        phase_s     = phase_r;
        case (state_r)
            IDLE: begin
                inact_s     = INACT_ZERO;
                blink_cnt_s = BLINK_ZERO;
                phase_s     = 1'b0;
                if (mode_rise_s) begin
                    state_s = SET_SEC;
                    sec_s   = clamp6(bus.SEC_IN, SEC_MAX);
                    min_s   = clamp6(bus.MIN_IN, MIN_MAX);
                    hour_s  = clamp5(bus.HOUR_IN, 5'd0, HOUR_MAX);
                    date_s  = clamp5(bus.DATE_IN, DATE_MIN, DATE_MAX);
                end else begin
                    sec_s  = bus.SEC_IN;
                    min_s  = bus.MIN_IN;
                    hour_s = bus.HOUR_IN;
                    date_s = bus.DATE_IN;
                end
            end
            SET_SEC, SET_MIN, SET_HOUR, SET_DATE: begin
                if (mode_fall_s || timeout_s) begin
                    // Leaving edit mode: commit on switch release, silent abort on timeout.
                    if (mode_fall_s) state_s = COMMIT;
                    else             state_s = IDLE;
                    inact_s     = INACT_ZERO;
                    blink_cnt_s = BLINK_ZERO;
                    phase_s     = 1'b0;
                end else begin
                    if (sel_rise_s) begin
                        // Select wins and swallows any coincident INC/DEC.
                        state_s = next_field(state_r);
                    end else if (inc_only_s || dec_only_s) begin
                        case (state_r)
                            SET_SEC:  sec_s  = step6(sec_r, 6'd0, SEC_MAX, inc_only_s);
                            SET_MIN:  min_s  = step6(min_r, 6'd0, MIN_MAX, inc_only_s);
                            SET_HOUR: hour_s = step5(hour_r, 5'd0, HOUR_MAX, inc_only_s);
                            SET_DATE: date_s = step5(date_r, DATE_MIN, DATE_MAX, inc_only_s);
                            default:  sec_s  = sec_r;
                        endcase
                    end else begin
                        state_s = state_r;
                    end

                    if (key_edge_s)    inact_s = INACT_ZERO;
                    else if (bus.TICK) inact_s = inact_r + INACT_ONE;
                    else               inact_s = inact_r;

                    // Key activity restarts the blink with the field visible.
                    if (key_edge_s) begin
                        blink_cnt_s = BLINK_ZERO;
                        phase_s     = 1'b0;
                    end else if (blink_cnt_r == BLINK_LAST) begin
                        blink_cnt_s = BLINK_ZERO;
                        phase_s     = ~phase_r;
                    end else begin
                        blink_cnt_s = blink_cnt_r + BLINK_ONE;
                    end
                end
            end
            COMMIT: begin
                state_s     = IDLE;
                inact_s     = INACT_ZERO;
                blink_cnt_s = BLINK_ZERO;
                phase_s     = 1'b0;
            end
            default: begin
                state_s     = IDLE;
                inact_s     = INACT_ZERO;
                blink_cnt_s = BLINK_ZERO;
                phase_s     = 1'b0;
            end
        endcase
    end

    // State, shadows, counters and outputs; outputs are derived from the
    // next state so they line up with the state they describe.
    always_ff @(posedge CLK100) begin
        if (RST) begin
            state_r     <= IDLE;
            sec_r       <= 6'd0;
            min_r       <= 6'd0;
            hour_r      <= 5'd0;
            date_r      <= DATE_MIN;
            inact_r     <= INACT_ZERO;
            blink_cnt_r <= BLINK_ZERO;
            phase_r     <= 1'b0;
            load_r      <= 1'b0;
            run_en_r    <= 1'b1;
            blink_r     <= FIELD_NONE;
        end else begin
            state_r     <= state_s;
            sec_r       <= sec_s;
            min_r       <= min_s;
            hour_r      <= hour_s;
            date_r      <= date_s;
            inact_r     <= inact_s;
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
            load_r      <= (state_s == COMMIT);
            run_en_r    <= (state_s == IDLE);
            blink_r     <= phase_s ? field_onehot(state_s) : FIELD_NONE;
        end
    end

    assign bus.SEC_OUT  = sec_r;
    assign bus.MIN_OUT  = min_r;
    assign bus.HOUR_OUT = hour_r;
    assign bus.DATE_OUT = date_r;
    assign bus.LOAD     = load_r;
    assign bus.RUN_EN   = run_en_r;
    assign bus.BLINK    = blink_r;

endmodule
